// File: rtl/pt_credit_tx.sv
// pt_credit_tx: credit-based stream transmitter.
// Upstream valid/ready in; registered valid-only beats out, gated by credits.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data, i_valid       upstream beat
//   o_ready               upstream ready (credits available)
//   o_tx_data, o_tx_valid registered link beat
//   i_credit              credit return, one per high cycle
//   o_credits             current credit count
//   o_idle                all credits home (receiver drained)
//   o_overflow            sticky: credit returned beyond CREDITS
module pt_credit_tx #(
    parameter type DATA_T = logic [31:0],
    parameter int CREDITS = 8,
    localparam int CREDIT_W = $clog2(CREDITS + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  DATA_T               i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output DATA_T               o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_credit,
    output logic [CREDIT_W-1:0] o_credits,
    output logic                o_idle,
    output logic                o_overflow
);

    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDITS);
    localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

    logic [CREDIT_W-1:0] credits_q;
    logic [CREDIT_W-1:0] credits_d;
    logic                send;
    logic                full;
    logic                credit_ok;
    logic                overflow_evt;

    // Ready looks only at the registered count: a returning credit
    // becomes usable the cycle after it arrives.
    assign o_ready   = (credits_q != '0);
    assign send      = i_valid && o_ready;
    assign full      = (credits_q == FULL);

    // A credit at a full counter is only legal when a send frees a
    // slot in the same cycle; otherwise it is dropped and flagged.
    assign overflow_evt = i_credit && full && !send;
    assign credit_ok    = i_credit && !overflow_evt;

    always_comb begin
        credits_d = credits_q;
        unique case ({send, credit_ok})
            2'b10:   credits_d = credits_q - ONE;
            2'b01:   credits_d = credits_q + ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            credits_q  <= FULL;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            o_tx_valid <= send;
            if (send) begin
                o_tx_data <= i_data;
            end
            if (overflow_evt) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_credits = credits_q;
    assign o_idle    = full;

endmodule

// File: tb/tb_pt_credit_tx.sv
// tb_pt_credit_tx: self-checking bench for pt_credit_tx.
// Directed scenarios plus randomized traffic against a credit-count model.
module tb_pt_credit_tx;

    localparam int CREDITS = 8;
    localparam int CW      = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [31:0]   i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [31:0]   o_tx_data;
    logic          o_tx_valid;
    logic          i_credit = 1'b0;
    logic [CW-1:0] o_credits;
    logic          o_idle;
    logic          o_overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: credits owned, sticky error, link register.
    int          m_cred = CREDITS;
    bit          m_ovf = 1'b0;
    bit          m_txv = 1'b0;
    logic [31:0] m_txd = '0;
    bit          last_send;
    logic [31:0] up_d = 32'h10;
    bit          rand_data = 1'b0;

    pt_credit_tx #(
        .DATA_T (logic [31:0]),
        .CREDITS(CREDITS)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_credit  (i_credit),
        .o_credits (o_credits),
        .o_idle    (o_idle),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_st();
        return {m_cred != 0, m_txv, CW'(m_cred), m_ovf, m_cred == CREDITS};
    endfunction

    function automatic logic [7:0] dut_st();
        return {o_ready, o_tx_valid, o_credits, o_overflow, o_idle};
    endfunction

    // Apply one cycle of stimulus, advance the clock, then update the
    // model from the rules: a beat goes when valid and a credit is held;
    // a credit comes back unless the count is already full and no beat
    // left this cycle, in which case it is lost and the error latches.
    task automatic tick(input bit v, input bit c, input bit r);
        bit s;
        i_valid  = v;
        i_data   = up_d;
        i_credit = c;
        i_rst    = r;
        s = !r && v && (m_cred > 0);
        @(posedge clk);
        #1;
        if (r) begin
            m_cred = CREDITS;
            m_ovf  = 1'b0;
            m_txv  = 1'b0;
            m_txd  = '0;
        end else begin
            if (c && m_cred == CREDITS && !s) begin
                m_ovf = 1'b1;
                m_cred = m_cred - int'(s);
            end else begin
                m_cred = m_cred - int'(s) + int'(c);
            end
            m_txv = s;
            if (s) m_txd = up_d;
        end
        last_send = s;
        if (s) up_d = rand_data ? $urandom : up_d + 32'h1;
        i_rst    = 1'b0;
        i_credit = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 0, 1);
        tick(0, 0, 0);
        n_vec++;
        if (dut_st() !== 8'b1_0_1000_0_1) begin
            n_err++;
            $display("FAIL reset status: got %b want %b",
                     dut_st(), 8'b1_0_1000_0_1);
        end
        n_vec++;
        if (o_tx_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset data: got %h want 0", o_tx_data);
        end
    endtask

    task automatic test_exhaustion();
        int nb = 0;
        up_d = 32'h10;
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0);
            if (o_tx_valid) nb++;
            n_vec++;
            if (dut_st() !== exp_st()) begin
                n_err++;
                $display("FAIL exhaust status cyc %0d: got %b want %b",
                         i, dut_st(), exp_st());
            end
            if (m_txv) begin
                n_vec++;
                if (o_tx_data !== m_txd) begin
                    n_err++;
                    $display("FAIL exhaust data cyc %0d: got %h want %h",
                             i, o_tx_data, m_txd);
                end
            end
        end
        n_vec++;
        if (nb != CREDITS || o_credits !== 4'd0) begin
            n_err++;
            $display("FAIL exhaust count: beats %0d credits %0d want 8 0",
                     nb, o_credits);
        end
    endtask

    task automatic test_credit_return();
        int nb = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1, 1, 0);
            n_vec++;
            if (o_ready !== 1'b1 || o_tx_valid !== 1'b0) begin
                n_err++;
                $display("FAIL return ready pulse %0d: got rdy %b v %b want 1 0",
                         k, o_ready, o_tx_valid);
            end
            tick(1, 0, 0);
            if (o_tx_valid) nb++;
            n_vec++;
            if (dut_st() !== exp_st() || o_tx_data !== m_txd) begin
                n_err++;
                $display("FAIL return beat %0d: got %b/%h want %b/%h",
                         k, dut_st(), o_tx_data, exp_st(), m_txd);
            end
        end
        n_vec++;
        if (nb != 4 || o_tx_data !== 32'h1b) begin
            n_err++;
            $display("FAIL return total: beats %0d last %h want 4 1b",
                     nb, o_tx_data);
        end
    endtask

    task automatic test_simultaneous();
        int nb = 0;
        tick(0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0);
            if (o_tx_valid) nb++;
            n_vec++;
            if (o_credits !== 4'd4 || dut_st() !== exp_st()) begin
                n_err++;
                $display("FAIL simul4 cyc %0d: got %b want cred 4 %b",
                         i, dut_st(), exp_st());
            end
        end
        n_vec++;
        if (nb != 10) begin
            n_err++;
            $display("FAIL simul4 beats: got %0d want 10", nb);
        end
        tick(0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0);
            n_vec++;
            if (o_credits !== 4'd8 || o_overflow !== 1'b0 ||
                o_tx_valid !== 1'b1) begin
                n_err++;
                $display("FAIL simul8 cyc %0d: got %b want cred 8 no ovf",
                         i, dut_st());
            end
        end
    endtask

    task automatic test_overflow();
        tick(0, 1, 0);
        n_vec++;
        if (o_credits !== 4'd8 || o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf set: got cred %0d ovf %b want 8 1",
                     o_credits, o_overflow);
        end
        for (int i = 0; i < 6; i++) begin
            tick(i[0], 0, 0);
            n_vec++;
            if (dut_st() !== exp_st()) begin
                n_err++;
                $display("FAIL ovf sticky cyc %0d: got %b want %b",
                         i, dut_st(), exp_st());
            end
        end
    endtask

    task automatic test_midstream_reset();
        while (m_cred > 3) tick(1, 0, 0);
        n_vec++;
        if (o_credits !== 4'd3 || o_tx_valid !== 1'b1 ||
            o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL midrst setup: got %b want cred 3 v 1 ovf 1",
                     dut_st());
        end
        tick(1, 1, 1);
        n_vec++;
        if (dut_st() !== 8'b1_0_1000_0_1 || o_tx_data !== 32'h0) begin
            n_err++;
            $display("FAIL midrst: got %b/%h want 10100001/0",
                     dut_st(), o_tx_data);
        end
    endtask

    task automatic test_random();
        bit v;
        bit c;
        bit r;
        rand_data = 1'b1;
        up_d = $urandom;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = (i < 300) ? ($urandom_range(0, 1) == 0)
                          : ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 99) == 0);
            tick(v, c, r);
            n_vec++;
            if (dut_st() !== exp_st()) begin
                n_err++;
                $display("FAIL random status cyc %0d: got %b want %b",
                         i, dut_st(), exp_st());
            end
            n_vec++;
            if (o_tx_data !== m_txd) begin
                n_err++;
                $display("FAIL random data cyc %0d: got %h want %h",
                         i, o_tx_data, m_txd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustion();
        test_credit_return();
        test_simultaneous();
        test_overflow();
        test_midstream_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pt_credit_tx.md
# pt_credit_tx

Credit-based stream transmitter. Sits on the producer side of a link whose far end is a fixed-depth receive buffer with no back-pressure wire. It accepts a valid/ready stream and forwards each beat as a registered, valid-only beat, sending only while it holds a credit. Each beat consumes one credit; each single-cycle credit pulse from the receiver, issued when it pops an entry, returns one.

## Interface
Parameters:
- DATA_T, default logic [31:0]: beat payload type.
- CREDITS, default 8: receiver buffer depth, equal to the initial credit count; must be ≥ 1.
- CREDIT_W (localparam), $clog2(CREDITS+1): width of the credit counter.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_data  input  DATA_T  upstream payload.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  upstream ready.
- o_tx_data  output  DATA_T  link payload, registered.
- o_tx_valid  output  1  link beat valid, registered, single cycle per beat.
- i_credit  input  1  credit return; one credit per high cycle.
- o_credits  output  CREDIT_W  current credit count.
- o_idle  output  1  high when o_credits == CREDITS, meaning all beats have been drained by the receiver.
- o_overflow  output  1  sticky error: a credit was returned beyond CREDITS.

## Operation
- send = i_valid && o_ready.
- o_ready = (credits_q != 0). This is combinational from the counter only; it must not depend on i_valid or on i_credit in the same cycle.
- Counter update: credits_q <= credits_q - send + credit_ok.
  - credit_ok = i_credit && !(credits_q == CREDITS && !send).
  - Arithmetic is CREDIT_W wide; the counter never wraps in either direction.
- Simultaneous send and credit: the count is unchanged. This includes the case credits_q == CREDITS, which is legal.
- Overflow: i_credit while credits_q == CREDITS and no send.
  - The credit is dropped and the counter holds at CREDITS.
  - o_overflow sets and stays high until reset.
- Output register:
  - o_tx_valid <= send.
  - o_tx_data <= i_data when send; otherwise it holds its previous value.
- o_credits = credits_q.
- o_idle = (credits_q == CREDITS).
- Reset values:
  - credits_q = CREDITS, so o_credits = CREDITS, o_ready = 1 and o_idle = 1.
  - o_tx_valid = 0, o_tx_data = 0, o_overflow = 0.
- Reset mid-operation:
  - Any beat in the output register is discarded; o_tx_valid is 0 in the cycle after reset is sampled.
  - Credits are restored to CREDITS.
  - An i_credit high in the same cycle as i_rst is ignored.
- Upstream protocol:
  - Once i_valid is raised, i_data is stable until accepted.
  - The block tolerates upstream violations without corrupting the count.

## Timing
- Accept-to-link latency: 1 cycle. A beat accepted at edge N appears with o_tx_valid = 1 in cycle N+1.
- Back-to-back throughput: 1 beat/cycle while credits_q > 0.
- From reset with no returns, exactly CREDITS consecutive beats are accepted; o_ready drops in the cycle after the last accept.
- Credit return at 0 credits: i_credit high in cycle N gives o_ready = 1 in cycle N+1. There is no same-cycle bypass.
- Sustained operation at 1 beat/cycle needs a link credit round trip shorter than CREDITS cycles; the block itself adds 1 cycle on each path.
- o_overflow rises in the cycle after the offending credit.

## Test plan
- Reset then idle:
  - Stimulus: release i_rst, CREDITS = 8, drive nothing.
  - Required: o_credits = 8, o_ready = 1, o_idle = 1, o_tx_valid = 0, o_overflow = 0.
- Credit exhaustion:
  - Stimulus: i_valid held high with data 0x10..0x19, no i_credit.
  - Required: exactly 8 beats 0x10..0x17 on the link on consecutive cycles, each one cycle after its accept; then o_ready = 0, o_credits = 0, o_tx_valid = 0; 0x18 is held upstream.
- Credit return:
  - Stimulus: from credits = 0, pulse i_credit for 1 cycle.
  - Required: o_ready = 1 the next cycle; 0x18 is accepted, then credits return to 0.
  - Stimulus: 3 further pulses.
  - Required: 3 further beats 0x19.. ; no beat is lost or duplicated.
- Simultaneous events:
  - Stimulus: credits = 4, send plus i_credit in the same cycle for 10 cycles.
  - Required: o_credits stays 4 and 10 beats are sent.
  - Stimulus: repeat at credits = 8.
  - Required: no overflow.
- Overflow:
  - Stimulus: at credits = 8 with i_valid = 0, pulse i_credit.
  - Required: o_credits stays 8; o_overflow = 1 next cycle and stays set until i_rst.
- Mid-stream reset:
  - Stimulus: at credits = 3 with a beat in flight, assert i_rst for 1 cycle while i_credit is high.
  - Required: next cycle o_tx_valid = 0, o_credits = 8, o_overflow = 0.
